// File: rtl/rev_pe_pkg.sv
// Shared types and constants for the reversible compute PE.
package rev_pe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAC = 2'd3
    } rev_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_e;

    localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/pe_buffer.sv
// Simple dual-port buffer: synchronous write, registered read (rdata resets to 0, array is not reset).
module pe_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rev_pe_lane.sv
// One operand pair: forward reversible op and reconstruction of a from the result.
module rev_pe_lane
    import rev_pe_pkg::*;
#(
    parameter int unsigned W  = 8,
    localparam int unsigned RW = 2 * W
) (
    input  logic [1:0]    mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [RW-1:0] acc_prev,
    input  logic          flt_inj,
    output logic [RW-1:0] r,
    output logic [RW-1:0] a_rec
);

    logic [RW-1:0] a_ext_s;
    logic [RW-1:0] b_ext_s;
    logic [RW-1:0] fwd_s;
    logic [RW-1:0] r_s;
    logic [RW-1:0] a_rec_s;

    assign a_ext_s = RW'(a);
    assign b_ext_s = RW'(b);

    // forward op, fault hook, then inverse; b==0 leaves the product non-invertible so a is passed through
    always_comb begin
        fwd_s   = {RW{1'b0}};
        a_rec_s = {RW{1'b0}};
        case (rev_op_e'(mode))
            OP_ADD:  fwd_s = a_ext_s + b_ext_s;
            OP_SUB:  fwd_s = a_ext_s - b_ext_s;
            OP_MUL:  fwd_s = a_ext_s * b_ext_s;
            OP_MAC:  fwd_s = acc_prev + a_ext_s * b_ext_s;
            default: fwd_s = a_ext_s + b_ext_s;
        endcase
        r_s = fwd_s ^ RW'(flt_inj);
        case (rev_op_e'(mode))
            OP_ADD:  a_rec_s = r_s - b_ext_s;
            OP_SUB:  a_rec_s = r_s + b_ext_s;
            OP_MUL:  a_rec_s = (b_ext_s != {RW{1'b0}}) ? (r_s / b_ext_s) : a_ext_s;
            OP_MAC:  a_rec_s = (b_ext_s != {RW{1'b0}}) ? ((r_s - acc_prev) / b_ext_s) : a_ext_s;
            default: a_rec_s = r_s - b_ext_s;
        endcase
    end

    assign r     = r_s;
    assign a_rec = a_rec_s;

endmodule

// File: rtl/rev_pe_multimode.sv
// Reversible compute PE: streams {b,a} pairs through ADD/SUB/MUL/MAC with online inverse checking.
// Optional REV_PE_ERR_LOG_EN adds err_cnt / err_addr mismatch logging.
module rev_pe_multimode
    import rev_pe_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned RW   = 2 * W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    cfg_mode,
    input  logic [AW-1:0] cfg_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_wen,
    input  logic [AW-1:0] in_waddr,
    input  logic [RW-1:0] in_wdata,
    input  logic          out_ren,
    input  logic [AW-1:0] out_raddr,
    output logic [RW-1:0] out_rdata,
    output logic          out_rvalid,
    input  logic          flt_inj,
    output logic          err,
    input  logic          err_clr
`ifdef REV_PE_ERR_LOG_EN
   ,output logic [AW:0]   err_cnt,
    output logic [AW-1:0] err_addr
`endif
);

    fsm_e          state_r, state_s;
    rev_op_e       mode_r;
    logic [AW-1:0] len_r, cnt_r;
    logic [1:0]    drain_cnt_r;
    logic          busy_r, done_r, rd_en_s, busy_nxt_s, done_nxt_s;
    logic          start_ok_s, last_s, drain_end_s;
    logic [RW-1:0] in_rdata_s, r_s, a_rec_s, acc_r;
    logic          rd_vld_r, wr_vld_r, mis_r, err_r, out_rvalid_r;
    logic [AW-1:0] rd_idx_r, wr_idx_r;
    logic [RW-1:0] wr_data_r;

    assign start_ok_s  = (state_r == IDLE) && start;
    assign last_s      = (cnt_r == (len_r - AW'(1)));
    assign drain_end_s = (drain_cnt_r == 2'(DRAIN_CYCLES - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = RUN;   else state_s = IDLE;
            RUN:     if (last_s) state_s = DRAIN; else state_s = RUN;
            DRAIN:   if (drain_end_s) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: read issue now, busy/done one cycle ahead of their registers
    always_comb begin
        rd_en_s    = 1'b0;
        busy_nxt_s = (state_s != IDLE);
        done_nxt_s = (state_r == DRAIN) && (state_s == IDLE);
        case (state_r)
            RUN:     rd_en_s = 1'b1;
            default: rd_en_s = 1'b0;
        endcase
    end

    // run control: config capture on start, element and drain counters, status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= OP_ADD;
            len_r       <= {AW{1'b0}};
            cnt_r       <= {AW{1'b0}};
            drain_cnt_r <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (start_ok_s) begin
                mode_r <= rev_op_e'(cfg_mode);
                len_r  <= cfg_len;
                cnt_r  <= {AW{1'b0}};
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + AW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            drain_cnt_r <= (state_r == DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
        end
    end

    pe_buffer #(.DATA_WIDTH(RW), .DEPTH(DEPTH)) u_in_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_wen && !busy_r),
        .waddr (in_waddr),
        .wdata (in_wdata),
        .re    (rd_en_s),
        .raddr (cnt_r),
        .rdata (in_rdata_s)
    );

    rev_pe_lane #(.W(W)) u_lane (
        .mode     (mode_r),
        .a        (in_rdata_s[W-1:0]),
        .b        (in_rdata_s[RW-1:W]),
        .acc_prev (acc_r),
        .flt_inj  (flt_inj),
        .r        (r_s),
        .a_rec    (a_rec_s)
    );

    // pipeline: operand-valid stage, then result/check stage feeding the output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r  <= 1'b0;
            rd_idx_r  <= {AW{1'b0}};
            wr_vld_r  <= 1'b0;
            wr_idx_r  <= {AW{1'b0}};
            wr_data_r <= {RW{1'b0}};
            mis_r     <= 1'b0;
            acc_r     <= {RW{1'b0}};
            err_r     <= 1'b0;
        end else begin
            rd_vld_r  <= rd_en_s;
            rd_idx_r  <= cnt_r;
            wr_vld_r  <= rd_vld_r;
            wr_idx_r  <= rd_idx_r;
            wr_data_r <= r_s;
            mis_r     <= rd_vld_r && (a_rec_s != RW'(in_rdata_s[W-1:0]));
            if (start_ok_s)                           acc_r <= {RW{1'b0}};
            else if (rd_vld_r && (mode_r == OP_MAC))  acc_r <= r_s;
            else                                      acc_r <= acc_r;
            // a mismatch arriving with err_clr still wins
            err_r <= (err_clr ? 1'b0 : err_r) | mis_r;
        end
    end

    pe_buffer #(.DATA_WIDTH(RW), .DEPTH(DEPTH)) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_vld_r),
        .waddr (wr_idx_r),
        .wdata (wr_data_r),
        .re    (out_ren && !busy_r),
        .raddr (out_raddr),
        .rdata (out_rdata)
    );

    // host read-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_rvalid_r <= 1'b0;
        else        out_rvalid_r <= out_ren && !busy_r;
    end

`ifdef REV_PE_ERR_LOG_EN
    logic [AW:0]   err_cnt_r;
    logic [AW-1:0] err_addr_r;

    // saturating per-run mismatch count and first-mismatch index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r  <= {(AW+1){1'b0}};
            err_addr_r <= {AW{1'b0}};
        end else begin
            if (start_ok_s || err_clr)                   err_cnt_r <= mis_r ? (AW+1)'(1) : {(AW+1){1'b0}};
            else if (mis_r && (err_cnt_r != {(AW+1){1'b1}})) err_cnt_r <= err_cnt_r + (AW+1)'(1);
            else                                         err_cnt_r <= err_cnt_r;
            if (mis_r && (!err_r || err_clr)) err_addr_r <= wr_idx_r;
            else if (err_clr)                 err_addr_r <= {AW{1'b0}};
            else                              err_addr_r <= err_addr_r;
        end
    end

    assign err_cnt  = err_cnt_r;
    assign err_addr = err_addr_r;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign out_rvalid = out_rvalid_r;

endmodule
